data_mem_ctrl: RTL and testbench

Parametrised data memory for the CPU load/store path, replacing the fixed 16x16 array with combinational read.
- Adds a request/ready handshake and a registered, configurable-latency read pipeline with a valid strobe.
- Adds byte-enabled writes, out-of-range error reporting, and a hardware zero-initialisation sweep after reset.
- Sits between the MEM stage and the pipeline's memory-wait logic.

---
 rtl/data_mem_pkg.sv | 33 +++
 rtl/mem_rd_pipe.sv | 67 ++++++
 rtl/data_mem_ctrl.sv | 108 ++++++++++
 tb/tb_data_mem_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the data memory controller.
package data_mem_pkg;

    // Controller FSM encoding
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Ceiling log2; returns 0 for values of 0 or 1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        if (value > 1) begin
            v = value - 1;
            while (v > 0) begin
                result++;
                v = v >> 1;
            end
        end
        return result;
    endfunction

    // Number of byte lanes in a data word
    function automatic int unsigned beWidth(input int unsigned dataW);
        return dataW / 8;
    endfunction

    // Legal parameter combinations: whole bytes, read latency 1..4
    function automatic bit paramsOk(input int unsigned dataW, input int unsigned rdLat);
        return (dataW > 0) && (dataW % 8 == 0) && (rdLat >= 1) && (rdLat <= 4);
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read response pipeline: delays {valid, err, data} by RD_LAT cycles and
// merges the single-cycle write-error flag into the registered err output.
module mem_rd_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inValid,
    input  logic              inErr,
    input  logic [DATA_W-1:0] inData,
    input  logic              wrErr,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    logic              validQ [1:RD_LAT];
    logic [DATA_W-1:0] dataQ  [1:RD_LAT];
    logic              rdErrArrive;

    // Valid/data shift; data stages only load behind a valid so rdata holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= RD_LAT; i++) begin
                validQ[i] <= 1'b0;
                dataQ[i]  <= '0;
            end
        end else begin
            validQ[1] <= inValid;
            if (inValid) dataQ[1] <= inData;
            for (int i = 2; i <= RD_LAT; i++) begin
                validQ[i] <= validQ[i-1];
                if (validQ[i-1]) dataQ[i] <= dataQ[i-1];
            end
        end
    end

    // Read error travels one stage short so err lands with rvalid
    if (RD_LAT == 1) begin : gErrLat1
        assign rdErrArrive = inValid & inErr;
    end else begin : gErrLatN
        logic errQ [1:RD_LAT-1];

        // Read-error shift register, qualified by valid on entry
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 1; i < RD_LAT; i++) errQ[i] <= 1'b0;
            end else begin
                errQ[1] <= inValid & inErr;
                for (int i = 2; i < RD_LAT; i++) errQ[i] <= errQ[i-1];
            end
        end

        assign rdErrArrive = errQ[RD_LAT-1];
    end

    // Registered error pulse: read error at RD_LAT, write error after one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err <= 1'b0;
        else       err <= rdErrArrive | wrErr;
    end

    assign rvalid = validQ[RD_LAT];
    assign rdata  = dataQ[RD_LAT];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory for the load/store path: zero-fill sweep after reset,
// byte-enabled writes, range checking and a fixed-latency read pipeline.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned RD_LAT        = 1,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err,
    output logic                  init_busy
);

    localparam int unsigned BE_W  = beWidth(DATA_W);
    localparam int unsigned IDX_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [0:0] RESET_STATE = (INIT_ON_RESET != 0) ? INIT : RUN;

    if (!paramsOk(DATA_W, RD_LAT)) begin : gBadParams
        $error("data_mem_ctrl: DATA_W must be a multiple of 8 and RD_LAT in 1..4");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [0:0]        state, nextState;
    logic [IDX_W-1:0]  ptr, nextPtr;
    logic              accept, inRange, rdAccept, wrEn, wrErr;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rdWord;

    // Sweep FSM next-state: walk ptr over every word, then run
    always_comb begin
        nextState = state;
        nextPtr   = ptr;
        case (state)
            INIT: begin
                nextPtr = ptr + 1'b1;
                if (ptr == LAST_IDX) begin
                    nextState = RUN;
                    nextPtr   = '0;
                end
            end
            default: ;
        endcase
    end

    // State register with registered ready/init_busy decoded from next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RESET_STATE;
            ptr       <= '0;
            ready     <= 1'b0;
            init_busy <= (INIT_ON_RESET != 0);
        end else begin
            state     <= nextState;
            ptr       <= nextPtr;
            ready     <= (nextState == RUN);
            init_busy <= (nextState == INIT);
        end
    end

    // Full-width range check before the array is ever indexed
    assign accept   = req & ready;
    assign inRange  = (addr < ADDR_W'(DEPTH));
    assign idx      = inRange ? IDX_W'(addr) : '0;
    assign rdWord   = inRange ? mem[idx] : '0;
    assign rdAccept = accept & ~we;
    assign wrEn     = accept & we & inRange;
    assign wrErr    = accept & we & ~inRange;

    // Array: cleared by the sweep only, otherwise byte-merged writes
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[ptr] <= '0;
        end else if (wrEn) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) uRdPipe (
        .clk     (clk),
        .reset   (reset),
        .inValid (rdAccept),
        .inErr   (~inRange),
        .inData  (rdWord),
        .wrErr   (wrErr),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .err     (err)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: a default-latency instance and an RD_LAT=3 instance share stimulus.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [15:0] addr, wdata;
    logic [1:0]  be;

    logic        readyA, rvalidA, errA, busyA;
    logic [15:0] rdataA;
    logic        readyB, rvalidB, errB, busyB;
    logic [15:0] rdataB;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    data_mem_ctrl uDutA (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(readyA), .rvalid(rvalidA), .rdata(rdataA), .err(errA), .init_busy(busyA)
    );

    data_mem_ctrl #(.RD_LAT(3)) uDutB (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(readyB), .rvalid(rvalidB), .rdata(rdataB), .err(errB), .init_busy(busyB)
    );

    typedef struct {
        logic        rq;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  b;
        logic        expV;
        logic [15:0] expD;
        logic        expE;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rq, input logic w, input logic [15:0] a,
                                input logic [15:0] d, input logic [1:0] b,
                                input logic ev, input logic [15:0] ed, input logic ee);
        vec_t v;
        v.rq = rq; v.w = w; v.a = a; v.d = d; v.b = b;
        v.expV = ev; v.expD = ed; v.expE = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic rq, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [1:0] b);
        req = rq; we = w; addr = a; wdata = d; be = b;
    endtask

    // Count negedge samples with init_busy high (bounded), watching for stray responses
    task automatic waitSweep(output int busyCycles, output int readyEarly, output int rvSeen);
        busyCycles = 0; readyEarly = 0; rvSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rvalidA || rvalidB) rvSeen++;
            if (!busyA) break;
            busyCycles++;
            if (readyA) readyEarly++;
        end
    endtask

    initial begin
        int          nBusy, nEarly, nRv, rvStray;
        logic        expV [7];
        logic [15:0] expD [7];

        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        check("rst_ready",  32'(readyA),  32'h0);
        check("rst_rvalid", 32'(rvalidA), 32'h0);
        check("rst_rdata",  32'(rdataA),  32'h0);
        check("rst_err",    32'(errA),    32'h0);
        check("rst_busyA",  32'(busyA),   32'h1);
        check("rst_busyB",  32'(busyB),   32'h1);

        // Sweep length after first release
        @(posedge clk); #1 reset = 1'b0;
        waitSweep(nBusy, nEarly, nRv);
        check("sweep1_len",   32'(nBusy),  32'd16);
        check("sweep1_early", 32'(nEarly), 32'd0);
        check("sweep1_ready", 32'(readyA), 32'h1);

        // Directed vectors against the RD_LAT=1 instance
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, 0, 16'(i), 16'h0, 2'b00, 1, 16'h0000, 0));
        vecs.push_back(mk(1, 1, 16'd5,    16'hA5C3, 2'b11, 0, 16'h0000, 0));
        vecs.push_back(mk(1, 0, 16'd5,    16'h0,    2'b00, 1, 16'hA5C3, 0));
        vecs.push_back(mk(1, 1, 16'd5,    16'h1234, 2'b01, 0, 16'hA5C3, 0));
        vecs.push_back(mk(1, 0, 16'd5,    16'h0,    2'b00, 1, 16'hA534, 0));
        vecs.push_back(mk(1, 1, 16'd5,    16'hFFFF, 2'b00, 0, 16'hA534, 0));
        vecs.push_back(mk(1, 0, 16'd5,    16'h0,    2'b00, 1, 16'hA534, 0));
        vecs.push_back(mk(1, 1, 16'd15,   16'hBEEF, 2'b11, 0, 16'hA534, 0));
        vecs.push_back(mk(1, 0, 16'h0010, 16'h0,    2'b00, 1, 16'h0000, 1));
        vecs.push_back(mk(1, 1, 16'hFFFF, 16'h0000, 2'b11, 0, 16'h0000, 1));
        vecs.push_back(mk(1, 0, 16'd15,   16'h0,    2'b00, 1, 16'hBEEF, 0));
        vecs.push_back(mk(1, 1, 16'd1,    16'h1111, 2'b11, 0, 16'hBEEF, 0));
        vecs.push_back(mk(1, 1, 16'd2,    16'h2222, 2'b11, 0, 16'hBEEF, 0));
        vecs.push_back(mk(1, 1, 16'd3,    16'h3333, 2'b11, 0, 16'hBEEF, 0));
        vecs.push_back(mk(0, 0, 16'd4,    16'h0,    2'b00, 0, 16'hBEEF, 0));

        for (int k = 0; k <= vecs.size(); k++) begin
            @(negedge clk);
            if (k > 0) begin
                check($sformatf("vec%0d_rvalid", k-1), 32'(rvalidA), 32'(vecs[k-1].expV));
                check($sformatf("vec%0d_rdata",  k-1), 32'(rdataA),  32'(vecs[k-1].expD));
                check($sformatf("vec%0d_err",    k-1), 32'(errA),    32'(vecs[k-1].expE));
            end else begin
                check("run_ready", 32'(readyA), 32'h1);
            end
            if (k < vecs.size())
                drive(vecs[k].rq, vecs[k].w, vecs[k].a, vecs[k].d, vecs[k].b);
            else
                drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        end

        // RD_LAT=3: back-to-back reads of 1,2,3 arrive at +3,+4,+5 in order
        expV = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        expD = '{16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h1111, 16'h2222, 16'h3333, 16'h3333};
        for (int n = 0; n <= 6; n++) begin
            @(negedge clk);
            if (n > 0) begin
                check($sformatf("lat3_c%0d_rvalid", n), 32'(rvalidB), 32'(expV[n]));
                check($sformatf("lat3_c%0d_rdata",  n), 32'(rdataB),  32'(expD[n]));
            end
            if (n < 3) drive(1'b1, 1'b0, 16'(n + 1), 16'h0, 2'b00);
            else       drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        end

        // RD_LAT=3: out-of-range read err and out-of-range write err land together
        for (int n = 0; n <= 4; n++) begin
            @(negedge clk);
            if (n > 0) begin
                check($sformatf("coll_c%0d_rvalidB", n), 32'(rvalidB), 32'(n == 3));
                check($sformatf("coll_c%0d_errB",    n), 32'(errB),    32'(n == 3));
            end
            if (n == 1) check("coll_oobread_rvalidA", 32'(rvalidA), 32'h1);
            if (n == 3) begin
                check("coll_rdataB",    32'(rdataB),  32'h0);
                check("coll_wrerr_A",   32'(errA),    32'h1);
                check("coll_wrerr_rvA", 32'(rvalidA), 32'h0);
            end
            if (n == 0)      drive(1'b1, 1'b0, 16'h0010, 16'h0,    2'b00);
            else if (n == 2) drive(1'b1, 1'b1, 16'h0020, 16'hDEAD, 2'b11);
            else             drive(1'b0, 1'b0, 16'h0,    16'h0,    2'b00);
        end

        // Reset with a read in flight, then reset again partway into the sweep
        @(negedge clk);
        drive(1'b1, 1'b0, 16'd1, 16'h0, 2'b00);
        @(posedge clk); #1 reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        @(negedge clk);
        check("inflight_rst_rvalidB", 32'(rvalidB), 32'h0);
        check("inflight_rst_busy",    32'(busyA),   32'h1);
        @(posedge clk); #1 reset = 1'b0;
        rvStray = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (rvalidA || rvalidB) rvStray++;
        end
        check("midsweep_busy", 32'(busyA), 32'h1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        waitSweep(nBusy, nEarly, nRv);
        check("sweep2_len",    32'(nBusy),            32'd16);
        check("sweep2_early",  32'(nEarly),           32'd0);
        check("sweep2_ready",  32'(readyA),           32'h1);
        check("no_stray_rv",   32'(rvStray + nRv),    32'd0);

        // Sweep cleared previously written words
        @(negedge clk); drive(1'b1, 1'b0, 16'd5, 16'h0, 2'b00);
        @(negedge clk); drive(1'b1, 1'b0, 16'd15, 16'h0, 2'b00);
        check("clr5_rvalid", 32'(rvalidA), 32'h1);
        check("clr5_rdata",  32'(rdataA),  32'h0);
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        check("clr15_rvalid", 32'(rvalidA), 32'h1);
        check("clr15_rdata",  32'(rdataA),  32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
